// File: rtl/sram_pkg.sv
// Shared types and sizes for the data-cache SRAM responder.
// Imported by the controller and its bench.
package sram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int SRAM_DATA_W    = 16;
    localparam int SRAM_ADDR_W    = 18;
    localparam int LINE_HALFWORDS = 4;
    localparam int WORD_HALFWORDS = 2;

endpackage

// File: rtl/sram_controller.sv
// Sequences 64-bit line reads and 32-bit word writes onto a
// 16-bit asynchronous SRAM, stalling the pipeline via ready.
module sram_controller
    import sram_pkg::*;
#(
    parameter int PHASE_CYCLES = 2,
    parameter int DATA_BASE    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [63:0]            rdata,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int             CW      = $clog2(PHASE_CYCLES);
    localparam logic [CW-1:0]  LAST    = CW'(PHASE_CYCLES - 1);
    localparam logic [18:0]    BASE    = 19'(DATA_BASE);
    localparam logic [1:0]     RD_LAST = 2'(LINE_HALFWORDS - 1);
    localparam logic [1:0]     WR_LAST = 2'(WORD_HALFWORDS - 1);

    state_e                 state_q, state_d;
    logic [1:0]             hw_q, hw_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [SRAM_ADDR_W-1:0] base_q, base_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [63:0]            rdata_q, rdata_d;

    logic [18:0] off;
    logic        phase_end;
    logic        dq_oe;
    logic        unused_addr;

    assign off         = address[18:0] - BASE;
    assign phase_end   = (cyc_q == LAST);
    assign unused_addr = ^address[31:19];

    always_comb begin
        state_d = state_q;
        hw_d    = hw_q;
        cyc_d   = cyc_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_en) begin
                    state_d = S_READ;
                    base_d  = {off[18:3], 2'b00};
                    hw_d    = '0;
                    cyc_d   = '0;
                end else if (wr_en) begin
                    state_d = S_WRITE;
                    base_d  = {off[18:2], 1'b0};
                    wdata_d = wdata;
                    hw_d    = '0;
                    cyc_d   = '0;
                end
            end
            S_READ: begin
                if (phase_end) begin
                    rdata_d[{hw_q, 4'b0000} +: SRAM_DATA_W] = SRAM_DQ;
                    cyc_d = '0;
                    hw_d  = hw_q + 2'd1;
                    if (hw_q == RD_LAST) state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (phase_end) begin
                    cyc_d = '0;
                    hw_d  = hw_q + 2'd1;
                    if (hw_q == WR_LAST) state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hw_q    <= '0;
            cyc_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hw_q    <= hw_d;
            cyc_q   <= cyc_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // WE rises on the last clock of a phase so the write commits with
    // address and data still stable.
    assign dq_oe     = (state_q == S_WRITE);
    assign SRAM_WE_N = ~(dq_oe & ~phase_end);
    assign SRAM_DQ   = dq_oe ? (hw_q[0] ? wdata_q[31:16] : wdata_q[15:0])
                             : {SRAM_DATA_W{1'bz}};

    always_comb begin
        SRAM_ADDR = '0;
        if (state_q == S_READ || state_q == S_WRITE)
            SRAM_ADDR = base_q + {16'b0, hw_q};
    end

    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            S_IDLE:  ready = ~(rd_en | wr_en);
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign rdata     = rdata_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus randomized bench for sram_controller against an
// array-based SRAM and a line/word reference memory.
module tb_sram_controller;
    import sram_pkg::*;

    localparam int P  = 2;
    localparam int DB = 1024;
    localparam int NW = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [63:0] rdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

    always #5 clk = ~clk;

    sram_controller #(.PHASE_CYCLES(P), .DATA_BASE(DB)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    function automatic logic [15:0] init_hw(int i);
        if (i == 6) return 16'h1234;
        if (i == 7) return 16'h5678;
        return 16'(i) ^ 16'hC3A5 ^ 16'(i >> 7);
    endfunction

    // External SRAM: drives the bus in read mode, commits on WE rise.
    logic [15:0] sram [0:NW-1];
    logic        model_oe = 1'b0;
    logic        probe = 1'b0;
    logic        prev_we = 1'b1;
    logic        filled = 1'b0;
    logic [17:0] wl_addr[$];
    logic [15:0] wl_data[$];

    assign SRAM_DQ = model_oe ? (probe ? 16'h0000 : sram[SRAM_ADDR]) : 16'hzzzz;

    always @(negedge clk) begin
        if (!filled) begin
            for (int i = 0; i < NW; i++) sram[i] <= init_hw(i);
            filled <= 1'b1;
        end
        if (SRAM_WE_N === 1'b1 && prev_we === 1'b0) begin
            sram[SRAM_ADDR] <= SRAM_DQ;
            wl_addr.push_back(SRAM_ADDR);
            wl_data.push_back(SRAM_DQ);
        end
        prev_we <= SRAM_WE_N;
    end

    logic [15:0] ref_mem [0:NW-1];
    int n_chk = 0;
    int n_pass = 0;
    logic [17:0] vis[$];
    bit we_low;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int offset(logic [31:0] a);
        int x;
        x = int'(a[18:0]) - DB;
        return ((x % 524288) + 524288) % 524288;
    endfunction

    task automatic do_op(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit hold);
        int lat, lat2, b;
        logic [63:0] exp_line;
        lat = 0;
        lat2 = 0;
        vis.delete();
        we_low = 1'b0;
        @(negedge clk);
        wl_addr.delete();
        wl_data.delete();
        rd_en = rd;
        wr_en = wr;
        address = a;
        wdata = d;
        model_oe = rd;
        probe = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (lat == 0) begin
                    lat = n;
                    if (!hold) break;
                end else begin
                    lat2 = n;
                    break;
                end
            end else if (lat == 0) begin
                if (vis.size() == 0 || vis[$] != SRAM_ADDR) vis.push_back(SRAM_ADDR);
                if (SRAM_WE_N !== 1'b1) we_low = 1'b1;
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        model_oe = 1'b0;
        if (rd) begin
            b = (offset(a) / 8) * 4;
            exp_line = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            chk("rd_latency", 64'(lat), 64'(4 * P + 1));
            chk("rd_line", rdata, exp_line);
            chk("rd_we_low", 64'(we_low), 64'd0);
            chk("rd_nvisit", 64'(vis.size()), 64'd4);
            for (int k = 0; k < 4; k++)
                chk("rd_addr", (vis.size() > k) ? 64'(vis[k]) : 64'hFFFF, 64'(b + k));
            if (hold) chk("rd_b2b_gap", 64'(lat2 - lat), 64'(4 * P + 2));
        end else begin
            b = (offset(a) / 4) * 2;
            chk("wr_latency", 64'(lat), 64'(2 * P + 1));
            chk("wr_ncommit", 64'(wl_addr.size()), 64'd2);
            for (int k = 0; k < 2; k++) begin
                chk("wr_addr", (wl_addr.size() > k) ? 64'(wl_addr[k]) : 64'hFFFF,
                    64'(b + k));
                chk("wr_data", (wl_data.size() > k) ? 64'(wl_data[k]) : 64'hFFFFF,
                    64'(k == 0 ? d[15:0] : d[31:16]));
            end
            ref_mem[b]   = d[15:0];
            ref_mem[b+1] = d[31:16];
            model_oe = 1'b1;
            probe = 1'b1;
            #1;
            chk("wr_done_hiz", 64'(SRAM_DQ), 64'd0);
            model_oe = 1'b0;
            probe = 1'b0;
        end
    endtask

    initial begin
        logic r;
        logic [31:0] ra, rw;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_hw(i);

        rd_en = 1'b1;
        @(negedge clk);
        chk("rst_ready_req", 64'(ready), 64'd0);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_we_n", 64'(SRAM_WE_N), 64'd1);
        chk("rst_addr", 64'(SRAM_ADDR), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        model_oe = 1'b1;
        probe = 1'b1;
        #1;
        chk("rst_hiz", 64'(SRAM_DQ), 64'd0);
        model_oe = 1'b0;
        probe = 1'b0;
        rst = 1'b0;

        do_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        do_op(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        chk("plan_line", rdata, 64'h5678_1234_DEAD_BEEF);
        do_op(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
        do_op(1'b1, 1'b0, 32'd1040, 32'h0, 1'b1);
        do_op(1'b1, 1'b0, 32'd1016, 32'h0, 1'b0);
        do_op(1'b0, 1'b1, 32'd1018, 32'h0BAD_F00D, 1'b0);
        do_op(1'b1, 1'b0, 32'd1016, 32'h0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            r  = 1'($urandom_range(0, 1));
            ra = 32'(DB - 64 + $urandom_range(0, 1023));
            rw = $urandom;
            do_op(r, ~r, ra, rw, 1'b0);
        end

        @(negedge clk);
        wr_en = 1'b1;
        address = 32'd1224;
        wdata = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        chk("mid_we_low", 64'(SRAM_WE_N), 64'd0);
        rst = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_we_n", 64'(SRAM_WE_N), 64'd1);
        chk("mid_ready", 64'(ready), 64'd1);
        chk("mid_rdata", rdata, 64'd0);
        chk("mid_addr", 64'(SRAM_ADDR), 64'd0);
        model_oe = 1'b1;
        probe = 1'b1;
        #1;
        chk("mid_hiz", 64'(SRAM_DQ), 64'd0);
        model_oe = 1'b0;
        probe = 1'b0;
        rst = 1'b0;
        do_op(1'b1, 1'b0, 32'd1536, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
